// File: rtl/tl_light_monitor.sv
// Receive-side safety monitor for the traffic-light code: reconstructs the
// 8-phase controller sequence from (La, Lb) and reports conflicts, illegal steps and stuck phases.
module tl_light_monitor #(
  parameter int MAX_DWELL = 16,
  parameter int DWELL_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         La,
  input  logic [1:0]         Lb,
  output logic               locked,
  output logic [2:0]         phase,
  output logic [DWELL_W-1:0] dwell,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [7:0]         err_cnt,
  output logic [7:0]         cycle_cnt
);

  typedef enum logic {SYNC = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [1:0] RED = 2'b00, YEL = 2'b01, GRN = 2'b10, LFT = 2'b11;
  localparam logic [1:0] ERR_NONE = 2'b00, ERR_ILLEGAL = 2'b01,
                         ERR_CONFLICT = 2'b10, ERR_TIMEOUT = 2'b11;

  state_t             state, state_n;
  logic [2:0]         phase_n;
  logic [DWELL_W-1:0] dwell_n;
  logic               err_n;
  logic [1:0]         err_code_n;
  logic [7:0]         err_cnt_n;
  logic [7:0]         cycle_cnt_n;
  logic [3:0]         pair;

  // Expected {La,Lb} for each phase of the sequence.
  function automatic logic [3:0] pattern(input logic [2:0] p);
    case (p)
      3'd0:    pattern = {GRN, RED};
      3'd1:    pattern = {YEL, RED};
      3'd2:    pattern = {LFT, RED};
      3'd3:    pattern = {YEL, RED};
      3'd4:    pattern = {RED, GRN};
      3'd5:    pattern = {RED, YEL};
      3'd6:    pattern = {RED, LFT};
      default: pattern = {RED, YEL};
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign pair   = {La, Lb};
  assign locked = (state == LOCK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SYNC;
      phase     <= '0;
      dwell     <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      err_cnt   <= '0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      dwell     <= dwell_n;
      err       <= err_n;
      err_code  <= err_code_n;
      err_cnt   <= err_cnt_n;
      cycle_cnt <= cycle_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    dwell_n     = dwell;
    err_n       = 1'b0;
    err_code_n  = ERR_NONE;
    err_cnt_n   = err_cnt;
    cycle_cnt_n = cycle_cnt;

    // Any error drops back to SYNC; conflict outranks everything else.
    if (La != RED && Lb != RED) begin
      state_n    = SYNC;
      phase_n    = '0;
      dwell_n    = '0;
      err_n      = 1'b1;
      err_code_n = ERR_CONFLICT;
      err_cnt_n  = sat_inc(err_cnt);
    end else if (state == SYNC) begin
      phase_n = '0;
      if (pair == pattern(3'd0)) begin
        state_n = LOCK;
        dwell_n = DWELL_W'(1);
      end else begin
        dwell_n = '0;
      end
    end else if (pair == pattern(phase)) begin
      if (dwell == DWELL_W'(MAX_DWELL)) begin
        state_n    = SYNC;
        phase_n    = '0;
        dwell_n    = '0;
        err_n      = 1'b1;
        err_code_n = ERR_TIMEOUT;
        err_cnt_n  = sat_inc(err_cnt);
      end else begin
        dwell_n = dwell + DWELL_W'(1);
      end
    end else if (pair == pattern(phase + 3'd1)) begin
      phase_n = phase + 3'd1;
      dwell_n = DWELL_W'(1);
      if (phase == 3'd7) cycle_cnt_n = cycle_cnt + 8'd1;
    end else begin
      state_n    = SYNC;
      phase_n    = '0;
      dwell_n    = '0;
      err_n      = 1'b1;
      err_code_n = ERR_ILLEGAL;
      err_cnt_n  = sat_inc(err_cnt);
    end
  end

endmodule
